// File: rtl/ddc_tone_sched.sv
// Staging-table scheduler: loads N_CH DDC phase configs, then issues one broadcast resync.
// Define DDC_SCHED_READBACK_EN to add the registered table readback port.
module ddc_tone_sched #(
   parameter int N_CH   = 4,
   parameter int CH_W   = 2,
   parameter int SETTLE = 8,
   parameter int FLUSH  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [CH_W-1:0] wr_addr,
   input  logic [19:0]     wr_pinc,
   input  logic [19:0]     wr_poff,
   output logic            wr_err,
   input  logic            commit,
   output logic            busy,
   output logic            done,
   output logic            data_ok,
   output logic [19:0]     cfg_pinc,
   output logic [19:0]     cfg_poff,
   output logic [N_CH-1:0] cfg_valid,
   output logic            resync
`ifdef DDC_SCHED_READBACK_EN
   ,
   input  logic [CH_W-1:0] rd_addr,
   output logic [19:0]     rd_pinc,
   output logic [19:0]     rd_poff
`endif
);

   localparam int CNT_MAX = (SETTLE > FLUSH) ? SETTLE : FLUSH;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_SYNC, S_FLUSH} state_t;

   state_t           state, state_nxt;
   logic [CH_W-1:0]  ch, ch_nxt, ld_idx;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [19:0]      tbl_pinc [N_CH];
   logic [19:0]      tbl_poff [N_CH];
   logic             wr_ok;
   logic [19:0]      ld_pinc, ld_poff, pinc_nxt, poff_nxt;
   logic [N_CH-1:0]  valid_nxt;
   logic             resync_nxt, done_nxt, busy_nxt, ok_nxt, wr_err_nxt;

   assign wr_ok      = wr_en && (state == S_IDLE) && (32'(wr_addr) < N_CH);
   assign wr_err_nxt = wr_en && !wr_ok;

   // A write landing on the same edge as the commit must be seen by the first load.
   assign ld_idx  = (state == S_IDLE || ch == LAST_CH) ? '0 : ch + 1'b1;
   assign ld_pinc = (wr_ok && wr_addr == ld_idx) ? wr_pinc : tbl_pinc[ld_idx];
   assign ld_poff = (wr_ok && wr_addr == ld_idx) ? wr_poff : tbl_poff[ld_idx];

   always_comb begin
      state_nxt  = state;
      ch_nxt     = ch;
      cnt_nxt    = cnt;
      valid_nxt  = '0;
      pinc_nxt   = cfg_pinc;
      poff_nxt   = cfg_poff;
      resync_nxt = 1'b0;
      done_nxt   = 1'b0;
      busy_nxt   = busy;
      ok_nxt     = data_ok;
      unique case (state)
         S_IDLE: begin
            if (commit) begin
               state_nxt = S_LOAD;
               ch_nxt    = '0;
               valid_nxt = N_CH'(1);
               pinc_nxt  = ld_pinc;
               poff_nxt  = ld_poff;
               busy_nxt  = 1'b1;
               ok_nxt    = 1'b0;
            end
         end
         S_LOAD: begin
            if (ch == LAST_CH) begin
               state_nxt = S_SETTLE;
               cnt_nxt   = '0;
            end else begin
               ch_nxt    = ld_idx;
               valid_nxt = N_CH'(1) << ld_idx;
               pinc_nxt  = ld_pinc;
               poff_nxt  = ld_poff;
            end
         end
         S_SETTLE: begin
            if (cnt == CNT_W'(SETTLE - 1)) begin
               state_nxt  = S_SYNC;
               resync_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_SYNC: begin
            state_nxt = S_FLUSH;
            cnt_nxt   = '0;
         end
         S_FLUSH: begin
            // Returning to IDLE here makes the done cycle able to accept a new commit.
            if (cnt == CNT_W'(FLUSH - 1)) begin
               state_nxt = S_IDLE;
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               ok_nxt    = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         ch        <= '0;
         cnt       <= '0;
         cfg_valid <= '0;
         cfg_pinc  <= '0;
         cfg_poff  <= '0;
         resync    <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
         data_ok   <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         state     <= state_nxt;
         ch        <= ch_nxt;
         cnt       <= cnt_nxt;
         cfg_valid <= valid_nxt;
         cfg_pinc  <= pinc_nxt;
         cfg_poff  <= poff_nxt;
         resync    <= resync_nxt;
         done      <= done_nxt;
         busy      <= busy_nxt;
         data_ok   <= ok_nxt;
         wr_err    <= wr_err_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            tbl_pinc[i] <= '0;
            tbl_poff[i] <= '0;
         end
      end else if (wr_ok) begin
         tbl_pinc[wr_addr] <= wr_pinc;
         tbl_poff[wr_addr] <= wr_poff;
      end
   end

`ifdef DDC_SCHED_READBACK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pinc <= '0;
         rd_poff <= '0;
      end else if (32'(rd_addr) < N_CH) begin
         rd_pinc <= tbl_pinc[rd_addr];
         rd_poff <= tbl_poff[rd_addr];
      end else begin
         rd_pinc <= '0;
         rd_poff <= '0;
      end
   end
`endif

endmodule

// File: doc/ddc_tone_sched.md
Name: ddc_tone_sched

Overview:
- Configuration scheduler for an array of N_CH quad-DDC channels.
- Holds a staging table of per-channel phase increment/offset words (20-bit, same format as the DDC pinc/poff ports).
- On commit, loads the channels one per cycle, waits for their phase pipelines to settle, then issues a single broadcast resync so all NCOs restart phase-aligned.
- Masks downstream data (data_ok) until the DDC pipelines have flushed post-resync.

Parameters:
- N_CH, 4, number of DDC channels driven.
- CH_W, 2, width of channel address; 2**CH_W >= N_CH.
- SETTLE, 8, idle cycles between last cfg_valid and resync; must be >= 6 (4-cycle p_valid delay plus phase-adder latency).
- FLUSH, 16, cycles after resync before data_ok reasserts; must be >= DDC datapath latency.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  staging-table write strobe.
- wr_addr  in  CH_W  channel index for write.
- wr_pinc  in  20  phase increment to stage.
- wr_poff  in  20  phase offset to stage.
- wr_err  out  1  one-cycle pulse: write dropped.
- commit  in  1  start reconfiguration (sampled in IDLE only).
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- data_ok  out  1  downstream DDC output trustworthy.
- cfg_pinc  out  20  pinc bus, shared by all channels.
- cfg_poff  out  20  poff bus, shared by all channels.
- cfg_valid  out  N_CH  one-hot per-channel p_valid.
- resync  out  1  broadcast resync, one-cycle pulse.
- rd_addr  in  CH_W  readback index (only with DDC_SCHED_READBACK_EN).
- rd_pinc  out  20  readback pinc (only with DDC_SCHED_READBACK_EN).
- rd_poff  out  20  readback poff (only with DDC_SCHED_READBACK_EN).

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, data_ok=0, table entries 0, state IDLE.
  - Release is synchronous to the next clk edge.
  - Reset mid-sequence aborts immediately; no resync is issued.
- All outputs are registered.
- Table write: accepted only when state IDLE and wr_addr < N_CH.
  - Otherwise dropped, with wr_err=1 on the following cycle.
  - A write and commit at the same edge: the write lands first, and the new value is loaded.
- FSM states: IDLE -> LOAD -> SETTLE -> SYNC -> FLUSH -> IDLE.
- IDLE: commit=1 -> LOAD, ch=0; busy=1 and data_ok=0 from the next cycle.
- LOAD: one channel per cycle.
  - cfg_valid = 1<<ch; cfg_pinc/cfg_poff = table[ch].
  - After ch=N_CH-1 -> SETTLE.
- SETTLE: cfg_valid=0, cfg buses hold their last value; count SETTLE cycles -> SYNC.
- SYNC: resync=1 for exactly one cycle -> FLUSH.
- FLUSH: count FLUSH cycles -> IDLE.
  - At entry to IDLE: done=1 for one cycle, busy=0, data_ok=1.
- Timing, with commit sampled at edge 0:
  - cfg_valid active cycles 1..N_CH.
  - resync at cycle N_CH+SETTLE+1.
  - done at cycle N_CH+SETTLE+FLUSH+2.
  - Defaults: cfg_valid 1-4, resync 13, done 30, busy high 1-29.
- commit while busy: ignored, with no side effect.
- A back-to-back commit in the done cycle is accepted: IDLE is active that cycle.
- Counters: ch (CH_W bits) and a single wait counter sized for max(SETTLE,FLUSH).
- data_ok stays 0 after reset until the first completed sequence.

Optional Feature:
- Macro: DDC_SCHED_READBACK_EN.
- Defined: rd_addr/rd_pinc/rd_poff ports exist.
  - rd_* return table[rd_addr] with 1-cycle registered latency, at any state.
  - rd_addr >= N_CH returns 0.
- Undefined: the ports and readback logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, commit with an empty table -> cfg_valid 0001,0010,0100,1000 on cycles 1-4 with pinc=poff=0; resync cycle 13; done cycle 30; data_ok 0->1 at cycle 30.
- Write ch2 pinc=0x12345, poff=0x00ABC; commit -> cycle 3: cfg_valid=0100, cfg_pinc=0x12345, cfg_poff=0x00ABC.
- wr_en during busy (cycle 5) and wr_addr=3 with N_CH=3 -> wr_err pulse the next cycle; table unchanged (verify via readback with DDC_SCHED_READBACK_EN).
- commit pulsed at cycles 5 and 20 -> ignored, exactly one resync; commit held in the done cycle -> second sequence starts, cfg_valid=0001 at cycle 31.
- rst_n low at cycle 10 (SETTLE) -> all outputs 0 asynchronously, no resync; table 0; data_ok stays 0.
- Same-edge write ch0 pinc=0x00001 and commit -> cycle 1: cfg_pinc=0x00001.
